ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  EX/MEM stage sitting directly downstream of the ID/EX register. Accepts one executed
//  instruction (control bits, ALU result, store data, dest reg), runs the data-memory
//  req/ack handshake for loads/stores with stall-back and timeout, and emits one MEM/WB
//  result per instruction to writeback. Single clock.
// PARAMETERS
//  DATA_W    32  width of ALU result, store data, memory address and data
//  RADDR_W   4   width of destination register address
//  MAX_WAIT  15  cycles in ACCESS without dmem_ack before abort (>=1)
// PORTS
//  clk                   in   1        clock, all state updates on rising edge
//  reset_n               in   1        asynchronous, active-low reset
//  in_valid              in   1        EX presents an instruction this cycle
//  in_ready              out  1        stage can accept (combinational: state==IDLE)
//  flush                 in   1        squash incoming / in-flight instruction
//  reg_write_enable_in   in   1        instruction writes register file
//  mem_write_enable_in   in   1        instruction is a store
//  mem_to_reg_select_in  in   1        instruction is a load
//  alu_result_in         in   DATA_W   ALU result / effective address
//  store_data_in         in   DATA_W   store data
//  write_addr_in         in   RADDR_W  destination register
//  dmem_req              out  1        memory request (registered)
//  dmem_we               out  1        1=write, 0=read; valid while dmem_req
//  dmem_addr             out  DATA_W   memory address; stable while dmem_req
//  dmem_wdata            out  DATA_W   write data; stable while dmem_req
//  dmem_ack              in   1        memory completes request this cycle
//  dmem_rdata            in   DATA_W   read data, valid when dmem_ack
//  wb_valid              out  1        one-cycle pulse: MEM/WB result valid
//  reg_write_enable_out  out  1        to WB: register write enable
//  mem_to_reg_out        out  1        to WB: result came from memory
//  write_addr_out        out  RADDR_W  to WB: destination register
//  wb_data_out           out  DATA_W   to WB: load data or ALU result
//  timeout_err           out  1        sticky: a memory access was aborted
// BEHAVIOUR
//  Reset (reset_n=0, async): state IDLE, every output and internal reg 0, counter 0.
//   Reset mid-ACCESS drops dmem_req immediately; no wb_valid for that instruction.
//  FSM IDLE/ACCESS. in_ready=1 only in IDLE. Accept = in_valid & in_ready & ~flush.
//  IDLE, accept, mem op (mem_write_enable_in|mem_to_reg_select_in): latch all inputs;
//   next edge: dmem_req=1, dmem_we=mem_write_enable_in, addr=alu_result_in,
//   wdata=store_data_in, state->ACCESS, counter=0. Both store+load bits set: store.
//  IDLE, accept, non-mem op: next edge wb_valid=1, wb_data_out=alu_result_in,
//   ctrl/write_addr outputs updated; stays IDLE. Latency 1; back-to-back each cycle.
//  ACCESS: dmem_req held with stable addr/we/wdata until ack. On edge with dmem_ack=1:
//   dmem_req=0, state->IDLE, wb_valid=1 (unless squashed); wb_data_out=dmem_rdata for
//   load, latched alu_result for store. Min mem-op latency 2 cycles (ack first cycle).
//  wb_valid is a single-cycle pulse; wb data/ctrl outputs hold until next update.
//  Squash: flush in IDLE blocks accept (flush beats in_valid). flush in ACCESS marks
//   instruction squashed: handshake still completes (store side effect not cancelled),
//   but wb_valid stays 0. Flush not re-sampled after marking.
//  Timeout: counter increments each ACCESS cycle without ack; when counter reaches
//   MAX_WAIT-1 with no ack, next edge: dmem_req=0, state->IDLE, timeout_err=1, no
//   wb_valid. Ack on that same edge wins (normal completion, no error).
//  timeout_err clears only on reset. dmem_ack in IDLE is ignored.
//  No combinational path from dmem_* inputs to dmem_* outputs.
// TESTING
//  Reset: assert reset_n=0 mid-ACCESS between edges -> dmem_req, wb_valid, state 0 at once.
//  ALU op: in_valid, alu_result_in=0x1234, write_addr_in=3, rw=1 -> next cycle
//   wb_valid=1, wb_data_out=0x1234, write_addr_out=3; 3 back-to-back ops -> 3 pulses.
//  Load: addr 0x40, ack 3 cycles after req with rdata=0xDEADBEEF -> in_ready=0 throughout,
//   addr stable, wb_valid one cycle after ack, wb_data_out=0xDEADBEEF, mem_to_reg_out=1.
//  Store + flush: store 0xA5 to 0x80, flush in ACCESS, ack later -> dmem_we=1 until ack,
//   no wb_valid, in_ready returns 1 after ack.
//  Timeout: MAX_WAIT=15, load never acked -> req drops after 15 ACCESS cycles,
//   timeout_err=1 and stays 1 across later ops until reset.
//  Same-cycle flush+in_valid in IDLE -> no accept, no req, no wb_valid.

Source files
------------

// File: rtl/ex_mem_stage.sv
//------------------------------------------------------------------------------
// ex_mem_stage
//   EX/MEM pipeline stage. It runs the data-memory req/ack handshake with a
//   timeout and emits one MEM/WB result per instruction.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ex_mem_stage #(
  parameter int DATA_W   = 32,
  parameter int RADDR_W  = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  input  logic               reg_write_enable_in,
  input  logic               mem_write_enable_in,
  input  logic               mem_to_reg_select_in,
  input  logic [DATA_W-1:0]  alu_result_in,
  input  logic [DATA_W-1:0]  store_data_in,
  input  logic [RADDR_W-1:0] write_addr_in,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               wb_valid,
  output logic               reg_write_enable_out,
  output logic               mem_to_reg_out,
  output logic [RADDR_W-1:0] write_addr_out,
  output logic [DATA_W-1:0]  wb_data_out,
  output logic               timeout_err
);

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(MAX_WAIT - 1);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_squash;
  logic               r_is_load;
  logic               r_rw;
  logic [RADDR_W-1:0] r_waddr;

  logic               r_dmem_req;
  logic               r_dmem_we;
  logic [DATA_W-1:0]  r_dmem_addr;
  logic [DATA_W-1:0]  r_dmem_wdata;
  logic               r_wb_valid;
  logic               r_wb_rw;
  logic               r_wb_m2r;
  logic [RADDR_W-1:0] r_wb_waddr;
  logic [DATA_W-1:0]  r_wb_data;
  logic               r_timeout_err;

  logic               w_accept;
  logic               w_mem_op;
  logic               w_accept_mem;
  logic               w_accept_alu;
  logic               w_ack_done;
  logic               w_timeout;
  logic               w_wb_fire;
  logic               w_wb_rw;
  logic               w_wb_m2r;
  logic [RADDR_W-1:0] w_wb_waddr;
  logic [DATA_W-1:0]  w_wb_data;

  assign in_ready     = (r_state == S_IDLE);
  assign w_accept     = in_valid & in_ready & ~flush;
  assign w_mem_op     = mem_write_enable_in | mem_to_reg_select_in;
  assign w_accept_mem = w_accept & w_mem_op;
  assign w_accept_alu = w_accept & ~w_mem_op;
  assign w_ack_done   = (r_state == S_ACCESS) & dmem_ack;
  assign w_timeout    = (r_state == S_ACCESS) & ~dmem_ack & (r_cnt == c_cnt_last);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept_mem) w_state_nxt = S_ACCESS;
      S_ACCESS: if (w_ack_done || w_timeout) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: what writeback sees on the next edge
  always_comb begin
    w_wb_fire  = 1'b0;
    w_wb_rw    = reg_write_enable_in;
    w_wb_m2r   = mem_to_reg_select_in;
    w_wb_waddr = write_addr_in;
    w_wb_data  = alu_result_in;
    case (r_state)
      S_IDLE: begin
        w_wb_fire = w_accept_alu;
      end
      S_ACCESS: begin
        // A flush arriving in the completion cycle still squashes the result
        w_wb_fire  = w_ack_done & ~(r_squash | flush);
        w_wb_rw    = r_rw;
        w_wb_m2r   = r_is_load;
        w_wb_waddr = r_waddr;
        w_wb_data  = r_is_load ? dmem_rdata : r_dmem_addr;
      end
      default: w_wb_fire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt         <= '0;
      r_squash      <= 1'b0;
      r_is_load     <= 1'b0;
      r_rw          <= 1'b0;
      r_waddr       <= '0;
      r_dmem_req    <= 1'b0;
      r_dmem_we     <= 1'b0;
      r_dmem_addr   <= '0;
      r_dmem_wdata  <= '0;
      r_wb_valid    <= 1'b0;
      r_wb_rw       <= 1'b0;
      r_wb_m2r      <= 1'b0;
      r_wb_waddr    <= '0;
      r_wb_data     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_dmem_req <= (w_state_nxt == S_ACCESS);
      r_wb_valid <= w_wb_fire;
      if (w_wb_fire) begin
        r_wb_rw    <= w_wb_rw;
        r_wb_m2r   <= w_wb_m2r;
        r_wb_waddr <= w_wb_waddr;
        r_wb_data  <= w_wb_data;
      end
      if (w_timeout) r_timeout_err <= 1'b1;
      if (w_accept_mem) begin
        r_dmem_we    <= mem_write_enable_in;
        r_dmem_addr  <= alu_result_in;
        r_dmem_wdata <= store_data_in;
        // Store wins when both load and store bits are set
        r_is_load    <= mem_to_reg_select_in & ~mem_write_enable_in;
        r_rw         <= reg_write_enable_in;
        r_waddr      <= write_addr_in;
        r_squash     <= 1'b0;
        r_cnt        <= '0;
      end else if (r_state == S_ACCESS) begin
        if (flush) r_squash <= 1'b1;
        if (!dmem_ack && (r_cnt != c_cnt_last)) r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign dmem_req             = r_dmem_req;
  assign dmem_we              = r_dmem_we;
  assign dmem_addr            = r_dmem_addr;
  assign dmem_wdata           = r_dmem_wdata;
  assign wb_valid             = r_wb_valid;
  assign reg_write_enable_out = r_wb_rw;
  assign mem_to_reg_out       = r_wb_m2r;
  assign write_addr_out       = r_wb_waddr;
  assign wb_data_out          = r_wb_data;
  assign timeout_err          = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
//------------------------------------------------------------------------------
// tb_ex_mem_stage
//   Randomized and directed bench for ex_mem_stage against a transaction model.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ex_mem_stage;

  localparam int DATA_W   = 32;
  localparam int RADDR_W  = 4;
  localparam int MAX_WAIT = 15;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               in_valid, in_ready, flush;
  logic               reg_write_enable_in, mem_write_enable_in, mem_to_reg_select_in;
  logic [DATA_W-1:0]  alu_result_in, store_data_in;
  logic [RADDR_W-1:0] write_addr_in;
  logic               dmem_req, dmem_we, dmem_ack;
  logic [DATA_W-1:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic               wb_valid, reg_write_enable_out, mem_to_reg_out, timeout_err;
  logic [RADDR_W-1:0] write_addr_out;
  logic [DATA_W-1:0]  wb_data_out;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .reg_write_enable_in(reg_write_enable_in),
    .mem_write_enable_in(mem_write_enable_in),
    .mem_to_reg_select_in(mem_to_reg_select_in),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in),
    .write_addr_in(write_addr_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .reg_write_enable_out(reg_write_enable_out),
    .mem_to_reg_out(mem_to_reg_out), .write_addr_out(write_addr_out),
    .wb_data_out(wb_data_out), .timeout_err(timeout_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: one outstanding memory op, counted in waited cycles
  typedef struct {
    logic [DATA_W-1:0]  alu;
    logic [DATA_W-1:0]  sd;
    logic               st;
    logic               ld;
    logic               rw;
    logic [RADDR_W-1:0] wa;
  } op_t;

  op_t                m_op;
  bit                 m_busy, m_sq;
  int                 m_waited;
  logic               e_req, e_we, e_wbv, e_rw, e_m2r, e_terr;
  logic [DATA_W-1:0]  e_addr, e_wdata, e_wbdata;
  logic [RADDR_W-1:0] e_wa;

  task automatic retire(input logic rw, input logic m2r, input logic [RADDR_W-1:0] wa,
                        input logic [DATA_W-1:0] d);
    e_wbv = 1'b1; e_rw = rw; e_m2r = m2r; e_wa = wa; e_wbdata = d;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_sq = 0; m_waited = 0;
      e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0;
      e_wbv = 0; e_rw = 0; e_m2r = 0; e_wa = '0; e_wbdata = '0; e_terr = 0;
    end else begin
      e_wbv = 1'b0;
      if (m_busy) begin
        if (flush) m_sq = 1;
        if (dmem_ack) begin
          m_busy = 0; e_req = 0;
          if (!m_sq) retire(m_op.rw, m_op.ld, m_op.wa, m_op.ld ? dmem_rdata : m_op.alu);
        end else begin
          m_waited++;
          if (m_waited == MAX_WAIT) begin
            m_busy = 0; e_req = 0; e_terr = 1;
          end
        end
      end else if (in_valid && !flush) begin
        if (mem_write_enable_in || mem_to_reg_select_in) begin
          m_op.alu = alu_result_in; m_op.sd = store_data_in;
          m_op.st  = mem_write_enable_in;
          m_op.ld  = mem_to_reg_select_in && !mem_write_enable_in;
          m_op.rw  = reg_write_enable_in; m_op.wa = write_addr_in;
          m_busy = 1; m_sq = 0; m_waited = 0;
          e_req = 1; e_we = m_op.st; e_addr = m_op.alu; e_wdata = m_op.sd;
        end else begin
          retire(reg_write_enable_in, mem_to_reg_select_in, write_addr_in, alu_result_in);
        end
      end
    end
  end

  // Compare process: every cycle outside reset
  always @(negedge clk) begin
    if (reset_n) begin
      chk("in_ready", in_ready, !m_busy);
      chk("dmem_req", dmem_req, e_req);
      if (e_req) begin
        chk("dmem_we", dmem_we, e_we);
        chk("dmem_addr", dmem_addr, e_addr);
        chk("dmem_wdata", dmem_wdata, e_wdata);
      end
      chk("wb_valid", wb_valid, e_wbv);
      chk("reg_write_enable_out", reg_write_enable_out, e_rw);
      chk("mem_to_reg_out", mem_to_reg_out, e_m2r);
      chk("write_addr_out", write_addr_out, e_wa);
      chk("wb_data_out", wb_data_out, e_wbdata);
      chk("timeout_err", timeout_err, e_terr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    in_valid = 0; flush = 0; reg_write_enable_in = 0; mem_write_enable_in = 0;
    mem_to_reg_select_in = 0; alu_result_in = '0; store_data_in = '0;
    write_addr_in = '0; dmem_ack = 0; dmem_rdata = '0;
  endtask

  task automatic drive_op(input logic st, input logic ld, input logic rw,
                          input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] sd,
                          input logic [RADDR_W-1:0] wa);
    in_valid = 1; mem_write_enable_in = st; mem_to_reg_select_in = ld;
    reg_write_enable_in = rw; alu_result_in = alu; store_data_in = sd; write_addr_in = wa;
  endtask

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      mem_write_enable_in  = ($urandom_range(0, 3) == 0);
      mem_to_reg_select_in = ($urandom_range(0, 2) == 0);
      reg_write_enable_in  = $urandom_range(0, 1);
      alu_result_in = $urandom; store_data_in = $urandom;
      write_addr_in = RADDR_W'($urandom);
      flush    = ($urandom_range(0, 9) == 0);
      dmem_ack = ($urandom_range(0, 4) == 0);
      dmem_rdata = $urandom;
      tick();
    end
    idle_inputs();
  endtask

  int pulses, n;

  initial begin
    reset_n = 0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #2 reset_n = 1;

    chk("reset dmem_req", dmem_req, 0);
    chk("reset wb_valid", wb_valid, 0);
    chk("reset wb_data_out", wb_data_out, 0);
    chk("reset timeout_err", timeout_err, 0);
    chk("reset in_ready", in_ready, 1);

    drive_op(0, 0, 1, 32'h1234, 32'h0, 4'd3);
    tick();
    chk("alu wb_valid", wb_valid, 1);
    chk("alu wb_data_out", wb_data_out, 32'h1234);
    chk("alu write_addr_out", write_addr_out, 3);
    chk("alu reg_write_enable_out", reg_write_enable_out, 1);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      drive_op(0, 0, 1, 32'h100 + 32'(i), 32'h0, RADDR_W'(i + 1));
      tick();
      pulses += int'(wb_valid);
    end
    idle_inputs();
    tick();
    chk("back-to-back pulses", pulses, 3);
    chk("alu idle wb_valid", wb_valid, 0);

    drive_op(0, 1, 1, 32'h40, 32'h0, 4'd5);
    tick();
    idle_inputs();
    chk("load dmem_req", dmem_req, 1);
    chk("load dmem_we", dmem_we, 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("load in_ready", in_ready, 0);
      chk("load addr stable", dmem_addr, 32'h40);
    end
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    tick();
    dmem_ack = 0;
    chk("load wb_valid", wb_valid, 1);
    chk("load wb_data_out", wb_data_out, 32'hDEADBEEF);
    chk("load mem_to_reg_out", mem_to_reg_out, 1);
    chk("load dmem_req dropped", dmem_req, 0);

    drive_op(1, 0, 0, 32'h80, 32'hA5, 4'd0);
    tick();
    idle_inputs();
    flush = 1;
    tick();
    flush = 0;
    chk("store dmem_we", dmem_we, 1);
    chk("store dmem_wdata", dmem_wdata, 32'hA5);
    tick();
    chk("store still req", dmem_req, 1);
    dmem_ack = 1;
    tick();
    dmem_ack = 0;
    chk("squashed wb_valid", wb_valid, 0);
    chk("store in_ready after ack", in_ready, 1);

    drive_op(0, 1, 1, 32'h50, 32'h0, 4'd2);
    flush = 1;
    tick();
    drive_op(0, 0, 1, 32'h77, 32'h0, 4'd2);
    chk("flush+valid dmem_req", dmem_req, 0);
    tick();
    idle_inputs();
    chk("flush+valid wb_valid", wb_valid, 0);

    drive_op(0, 1, 1, 32'h44, 32'h0, 4'd6);
    tick();
    idle_inputs();
    n = 0;
    while (dmem_req && n < 40) begin
      n++;
      tick();
    end
    chk("timeout access cycles", n, 15);
    chk("timeout_err set", timeout_err, 1);
    chk("timeout no wb_valid", wb_valid, 0);
    drive_op(0, 0, 1, 32'h9, 32'h0, 4'd1);
    tick();
    idle_inputs();
    chk("timeout_err sticky", timeout_err, 1);
    chk("post-timeout alu wb", wb_data_out, 32'h9);

    random_cycles(3000);

    // Asynchronous reset between edges while a load is in flight
    drive_op(0, 1, 0, 32'h60, 32'h0, 4'd4);
    n = 0;
    while (!dmem_req && n < 20) begin
      n++;
      tick();
    end
    idle_inputs();
    chk("pre-reset dmem_req", dmem_req, 1);
    #1 reset_n = 0;
    #1;
    chk("async reset dmem_req", dmem_req, 0);
    chk("async reset wb_valid", wb_valid, 0);
    chk("async reset in_ready", in_ready, 1);
    chk("async reset timeout_err", timeout_err, 0);
    tick();
    reset_n = 1;

    random_cycles(1000);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
